// File: rtl/vga_reg_rd.sv
// VGA register read responder: status, scanline, frame count and bgcol on the CPU bus.
// Optional frame interrupt with STATUS bit7 mask under `VGAREG_IRQ_EN.
module vga_reg_rd #(
   parameter int SYNC_STAGES = 2,
   parameter int LINE_W      = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        addr,
   input  logic              _vga_io,
   input  logic              _rd,
   input  logic              vsync,
   input  logic              vblank,
   input  logic [LINE_W-1:0] scanline,
   input  logic [7:0]        bgcol,
   inout  wire  [7:0]        data,
   output logic              irq
`ifdef VGAREG_IRQ_EN
   ,
   input  logic              irq_mask
`endif
);

   logic                   rd_act;
   logic                   rd_s;
   logic                   rd_rise;
   logic                   rd_fall;
   logic                   vs_rise;
   logic                   irq_ena;
   logic [7:0]             sel;
   logic [1:0]             line_hi;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   rd_dly_q, rd_dly_d;
   logic [7:0]             hold_q, hold_d;
   logic [1:0]             addr_cap_q, addr_cap_d;
   logic [1:0]             snap_q, snap_d;
   logic                   vs_q, vs_d;
   logic                   pend_q, pend_d;
   logic                   ovf_q, ovf_d;
   logic [3:0]             cnt_q, cnt_d;

   // Output enable follows the raw strobes so the bus is up while the CPU samples.
   assign rd_act  = ~_vga_io & ~_rd;
   assign data    = rd_act ? hold_q : 8'bzzzz_zzzz;

   assign rd_s    = sync_q[SYNC_STAGES-1];
   assign rd_rise = rd_s & ~rd_dly_q;
   assign rd_fall = ~rd_s & rd_dly_q;
   assign vs_rise = vsync & ~vs_q;
   assign line_hi = 2'(scanline >> 8);

`ifdef VGAREG_IRQ_EN
   assign irq_ena = irq_mask;
`else
   assign irq_ena = 1'b0;
`endif

   always_comb begin
      sel = 8'h00;
      unique case (addr)
         2'd0: sel = {irq_ena, 4'b0000, ovf_q, pend_q, vblank};
         2'd1: sel = bgcol;
         2'd2: sel = scanline[7:0];
         2'd3: sel = {cnt_q, 2'b00, snap_q};
      endcase
   end

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], rd_act};
      rd_dly_d   = rd_s;
      hold_d     = rd_s ? hold_q : sel;
      addr_cap_d = rd_rise ? addr : addr_cap_q;
      snap_d     = (rd_rise && addr == 2'd2) ? line_hi : snap_q;
      vs_d       = vsync;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      ovf_d      = ovf_q;
      if (vs_rise) begin
         cnt_d  = cnt_q + 4'd1;
         pend_d = 1'b1;
         // A vsync on the clearing edge keeps ovf as it was.
         if (!(rd_fall && addr_cap_q == 2'd0))
            ovf_d = ovf_q | pend_q;
      end else if (rd_fall && addr_cap_q == 2'd0) begin
         pend_d = 1'b0;
         ovf_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q     <= '0;
         rd_dly_q   <= 1'b0;
         hold_q     <= 8'h00;
         addr_cap_q <= 2'd0;
         snap_q     <= 2'd0;
         vs_q       <= 1'b0;
         pend_q     <= 1'b0;
         ovf_q      <= 1'b0;
         cnt_q      <= 4'd0;
      end else begin
         sync_q     <= sync_d;
         rd_dly_q   <= rd_dly_d;
         hold_q     <= hold_d;
         addr_cap_q <= addr_cap_d;
         snap_q     <= snap_d;
         vs_q       <= vs_d;
         pend_q     <= pend_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
      end
   end

`ifdef VGAREG_IRQ_EN
   logic irq_q, irq_d;

   always_comb irq_d = pend_q & irq_ena;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) irq_q <= 1'b0;
      else       irq_q <= irq_d;
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_vga_reg_rd.sv
// Bench for vga_reg_rd: directed cases plus random ops against a frame/register model.
module tb_vga_reg_rd;

   localparam int SYNC = 2;

   logic       clk;
   logic       reset;
   logic [1:0] addr;
   logic       vga_io_n;
   logic       rd_n;
   logic       vsync;
   logic       vblank;
   logic [9:0] scanline;
   logic [7:0] bgcol;
   logic       irq;
   wire  [7:0] data;
`ifdef VGAREG_IRQ_EN
   logic       irq_mask;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   bit       m_pend;
   bit       m_ovf;
   int       m_cnt;
   bit [1:0] m_snap;
   logic [7:0] got;

   for (genvar i = 0; i < 8; i++) begin : g_pu
      pullup (data[i]);
   end

   vga_reg_rd #(.SYNC_STAGES(SYNC), .LINE_W(10)) dut (
      .clk(clk),
      .reset(reset),
      .addr(addr),
      ._vga_io(vga_io_n),
      ._rd(rd_n),
      .vsync(vsync),
      .vblank(vblank),
      .scanline(scanline),
      .bgcol(bgcol),
      .data(data),
      .irq(irq)
`ifdef VGAREG_IRQ_EN
      ,
      .irq_mask(irq_mask)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit ena_bit();
`ifdef VGAREG_IRQ_EN
      return irq_mask;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] m_reg(input logic [1:0] a);
      logic [3:0] c;
      c = 4'(m_cnt);
      case (a)
         2'd0:    return {ena_bit(), 4'b0000, m_ovf, m_pend, vblank};
         2'd1:    return bgcol;
         2'd2:    return scanline[7:0];
         default: return {c, 2'b00, m_snap};
      endcase
   endfunction

   function automatic logic m_irq();
      return m_pend & ena_bit();
   endfunction

   task automatic m_reset();
      m_pend = 0;
      m_ovf  = 0;
      m_cnt  = 0;
      m_snap = 2'b00;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      m_reset();
      @(negedge clk);
   endtask

   task automatic vs_pulse();
      @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
      @(negedge clk);
      m_cnt = (m_cnt + 1) % 16;
      if (m_pend) m_ovf = 1;
      m_pend = 1;
   endtask

   task automatic do_read(input logic [1:0] a, input int clks, output logic [7:0] v);
      @(negedge clk);
      addr     = a;
      vga_io_n = 1'b0;
      rd_n     = 1'b0;
      repeat (clks) @(negedge clk);
      v        = data;
      vga_io_n = 1'b1;
      rd_n     = 1'b1;
      repeat (SYNC + 3) @(negedge clk);
   endtask

   task automatic m_after_read(input logic [1:0] a);
      if (a == 2'd0) begin
         m_pend = 0;
         m_ovf  = 0;
      end
      if (a == 2'd2) m_snap = scanline[9:8];
   endtask

   task automatic rd_exp(input string tag, input logic [1:0] a, input logic [7:0] exp);
      logic [7:0] v;
      do_read(a, $urandom_range(SYNC + 2, SYNC + 6), v);
      chk(tag, v, exp);
      m_after_read(a);
   endtask

   task automatic rd_model(input string tag, input logic [1:0] a);
      rd_exp(tag, a, m_reg(a));
   endtask

   initial begin
      reset    = 1'b1;
      addr     = 2'd0;
      vga_io_n = 1'b1;
      rd_n     = 1'b1;
      vsync    = 1'b0;
      vblank   = 1'b0;
      scanline = 10'd0;
      bgcol    = 8'h00;
`ifdef VGAREG_IRQ_EN
      irq_mask = 1'b0;
`endif
      m_reset();
      repeat (3) @(negedge clk);
      chk("idle_in_reset", data, 8'hFF);
      chk("irq_in_reset", irq, 1'b0);
      reset = 1'b0;
      @(negedge clk);

      vga_io_n = 1'b0;
      @(negedge clk);
      chk("cs_only_hiz", data, 8'hFF);
      vga_io_n = 1'b1;
      rd_n     = 1'b0;
      @(negedge clk);
      chk("rd_only_hiz", data, 8'hFF);
      rd_n = 1'b1;
      chk("irq_idle", irq, 1'b0);
      do_read(2'd0, 6, got);
      chk("status_reset", got, 8'h00);

      vblank = 1'b1;
      vs_pulse();
      rd_exp("status_pend", 2'd0, 8'h03);
      rd_exp("status_cleared", 2'd0, 8'h01);

      vblank = 1'b0;
      repeat (3) vs_pulse();
      rd_exp("status_ovf", 2'd0, 8'h06);
      rd_exp("status_ovf_clr", 2'd0, 8'h00);

      scanline = 10'h2A5;
      rd_exp("line_lo", 2'd2, 8'hA5);
      scanline = 10'h000;
      rd_exp("line_hi_snap", 2'd3, 8'h42);

      do_reset();
      repeat (17) vs_pulse();
      rd_exp("cnt_wrap", 2'd3, 8'h10);
      rd_exp("status_after17", 2'd0, 8'h06);

`ifdef VGAREG_IRQ_EN
      irq_mask = 1'b1;
      @(negedge clk);
      chk("irq_no_pend", irq, 1'b0);
      vs_pulse();
      chk("irq_set", irq, 1'b1);
      rd_exp("status_mask", 2'd0, 8'h82);
      chk("irq_clr", irq, 1'b0);
`else
      vs_pulse();
      chk("irq_tied", irq, 1'b0);
      rd_exp("status_nomask", 2'd0, 8'h02);
`endif

      vs_pulse();
      @(negedge clk);
      addr     = 2'd0;
      vga_io_n = 1'b0;
      rd_n     = 1'b0;
      repeat (5) @(negedge clk);
      chk("coinc_read", data, m_reg(2'd0));
      vga_io_n = 1'b1;
      rd_n     = 1'b1;
      repeat (SYNC) @(posedge clk);
      @(negedge clk);
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
      m_cnt = (m_cnt + 1) % 16;
      m_pend = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("coinc_irq", irq, m_irq());
      end
      rd_model("coinc_status", 2'd0);
      rd_model("coinc_cnt", 2'd3);

      bgcol = 8'h5A;
      @(negedge clk);
      addr     = 2'd1;
      vga_io_n = 1'b0;
      rd_n     = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_reset_read", data, 8'h5A);
      reset = 1'b1;
      @(negedge clk);
      chk("reset_mid_read", data, 8'h00);
      chk("reset_irq", irq, 1'b0);
      reset = 1'b0;
      m_reset();
      repeat (SYNC + 4) @(negedge clk);
      chk("post_reset_read", data, 8'h5A);
      vga_io_n = 1'b1;
      rd_n     = 1'b1;
      repeat (SYNC + 3) @(negedge clk);
      rd_model("post_reset_status", 2'd0);

      for (int it = 0; it < 80; it++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op <= 2) begin
            vs_pulse();
         end else if (op <= 7) begin
            rd_model("rand_read", 2'($urandom_range(0, 3)));
         end else begin
            @(negedge clk);
            vblank   = 1'($urandom);
            bgcol    = 8'($urandom);
            scanline = 10'($urandom);
`ifdef VGAREG_IRQ_EN
            irq_mask = 1'($urandom);
`endif
            repeat (2) @(negedge clk);
         end
         chk("rand_irq", irq, m_irq());
         chk("rand_idle", data, 8'hFF);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
